// File: rtl/phase_pkg.sv
// Shared definitions for consumers of the start/stop detector's phase_tag stream.
package phase_pkg;

   typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} avg_state_t;

   localparam int unsigned MISSED_COUNT_W = 16;

   // Modular successor of a sequence number held in the low 'width' bits.
   function automatic logic [31:0] seq_next(input logic [31:0] seq, input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (seq + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/phase_tag_averager.sv
// Averages contiguous phase tags over 2^log2_window samples, tracking min/max and
// counting sequence discontinuities reported through the clk_0 count field.
module phase_tag_averager
   import phase_pkg::*;
#(
   parameter int unsigned phase_count_size = 12,
   parameter int unsigned clk_0_count_size = 4,
   parameter int unsigned log2_window      = 4
) (
   input  logic                                       clk_sample,
   input  logic                                       rst,
   input  logic [phase_count_size+clk_0_count_size-1:0] phase_tag,
   input  logic                                       phase_tag_valid,
   input  logic                                       clear,
   output logic [phase_count_size-1:0]                phase_avg,
   output logic [phase_count_size-1:0]                phase_min,
   output logic [phase_count_size-1:0]                phase_max,
   output logic                                       avg_valid,
   output logic                                       missed_tag,
   output logic [MISSED_COUNT_W-1:0]                  missed_count
);

   localparam int unsigned PW   = phase_count_size;
   localparam int unsigned SW   = clk_0_count_size;
   localparam int unsigned LW   = log2_window;
   localparam int unsigned AccW = PW + LW;
   localparam logic [LW:0] WinCount = {1'b1, {LW{1'b0}}};

   logic [SW-1:0] seq;
   logic [PW-1:0] phase;

   assign seq   = phase_tag[PW+SW-1:PW];
   assign phase = phase_tag[PW-1:0];

   avg_state_t state_q, state_d;
   logic [AccW-1:0]           acc_q, acc_d;
   logic [PW-1:0]             win_min_q, win_min_d;
   logic [PW-1:0]             win_max_q, win_max_d;
   logic [LW:0]               n_q, n_d;
   logic [SW-1:0]             last_seq_q, last_seq_d;
   logic [PW-1:0]             avg_q, avg_d;
   logic [PW-1:0]             pub_min_q, pub_min_d;
   logic [PW-1:0]             pub_max_q, pub_max_d;
   logic                      avg_valid_q, avg_valid_d;
   logic                      missed_q, missed_d;
   logic [MISSED_COUNT_W-1:0] missed_cnt_q, missed_cnt_d;

   logic            seq_contig;
   logic [AccW-1:0] acc_sum;
   logic [LW:0]     n_sum;
   logic [PW-1:0]   min_upd;
   logic [PW-1:0]   max_upd;

   assign seq_contig = (32'(seq) == seq_next(32'(last_seq_q), SW));
   assign acc_sum    = acc_q + AccW'(phase);
   assign n_sum      = n_q + 1'b1;
   assign min_upd    = (phase < win_min_q) ? phase : win_min_q;
   assign max_upd    = (phase > win_max_q) ? phase : win_max_q;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      win_min_d    = win_min_q;
      win_max_d    = win_max_q;
      n_d          = n_q;
      last_seq_d   = last_seq_q;
      avg_d        = avg_q;
      pub_min_d    = pub_min_q;
      pub_max_d    = pub_max_q;
      avg_valid_d  = 1'b0;
      missed_d     = 1'b0;
      missed_cnt_d = missed_cnt_q;

      if (clear) begin
         // Tag arriving with clear is dropped; published results are kept.
         state_d      = S_IDLE;
         acc_d        = '0;
         win_min_d    = '0;
         win_max_d    = '0;
         n_d          = '0;
         missed_cnt_d = '0;
      end else if (phase_tag_valid) begin
         unique case (state_q)
            S_IDLE: begin
               state_d    = S_ACCUM;
               acc_d      = AccW'(phase);
               win_min_d  = phase;
               win_max_d  = phase;
               n_d        = (LW+1)'(1);
               last_seq_d = seq;
            end
            S_ACCUM: begin
               if (seq_contig) begin
                  last_seq_d = seq;
                  if (n_sum == WinCount) begin
                     state_d     = S_IDLE;
                     avg_d       = acc_sum[AccW-1:LW];
                     pub_min_d   = min_upd;
                     pub_max_d   = max_upd;
                     avg_valid_d = 1'b1;
                     acc_d       = '0;
                     win_min_d   = '0;
                     win_max_d   = '0;
                     n_d         = '0;
                  end else begin
                     acc_d     = acc_sum;
                     win_min_d = min_upd;
                     win_max_d = max_upd;
                     n_d       = n_sum;
                  end
               end else begin
                  // Offending tag becomes sample 1 of a fresh window.
                  missed_d   = 1'b1;
                  if (missed_cnt_q != '1) begin
                     missed_cnt_d = missed_cnt_q + 1'b1;
                  end
                  acc_d      = AccW'(phase);
                  win_min_d  = phase;
                  win_max_d  = phase;
                  n_d        = (LW+1)'(1);
                  last_seq_d = seq;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sample or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         acc_q        <= '0;
         win_min_q    <= '0;
         win_max_q    <= '0;
         n_q          <= '0;
         last_seq_q   <= '0;
         avg_q        <= '0;
         pub_min_q    <= '0;
         pub_max_q    <= '0;
         avg_valid_q  <= 1'b0;
         missed_q     <= 1'b0;
         missed_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         win_min_q    <= win_min_d;
         win_max_q    <= win_max_d;
         n_q          <= n_d;
         last_seq_q   <= last_seq_d;
         avg_q        <= avg_d;
         pub_min_q    <= pub_min_d;
         pub_max_q    <= pub_max_d;
         avg_valid_q  <= avg_valid_d;
         missed_q     <= missed_d;
         missed_cnt_q <= missed_cnt_d;
      end
   end

   assign phase_avg    = avg_q;
   assign phase_min    = pub_min_q;
   assign phase_max    = pub_max_q;
   assign avg_valid    = avg_valid_q;
   assign missed_tag   = missed_q;
   assign missed_count = missed_cnt_q;

endmodule

// File: tb/tb_phase_tag_averager.sv
// Directed and randomized checks of phase_tag_averager against a queue-based window model.
module tb_phase_tag_averager;

   localparam int PW  = 12;
   localparam int SW  = 4;
   localparam int LW  = 2;
   localparam int WIN = 1 << LW;

   logic           clk_sample = 1'b0;
   logic           rst = 1'b1;
   logic [PW+SW-1:0] phase_tag = '0;
   logic           phase_tag_valid = 1'b0;
   logic           clear = 1'b0;
   logic [PW-1:0]  phase_avg;
   logic [PW-1:0]  phase_min;
   logic [PW-1:0]  phase_max;
   logic           avg_valid;
   logic           missed_tag;
   logic [15:0]    missed_count;

   phase_tag_averager #(
      .phase_count_size(PW),
      .clk_0_count_size(SW),
      .log2_window     (LW)
   ) dut (
      .clk_sample     (clk_sample),
      .rst            (rst),
      .phase_tag      (phase_tag),
      .phase_tag_valid(phase_tag_valid),
      .clear          (clear),
      .phase_avg      (phase_avg),
      .phase_min      (phase_min),
      .phase_max      (phase_max),
      .avg_valid      (avg_valid),
      .missed_tag     (missed_tag),
      .missed_count   (missed_count)
   );

   always #5 clk_sample = ~clk_sample;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int av_pulses = 0;

   // Reference model state
   int win[$];
   bit active = 0;
   int last_seq = 0;
   int exp_avg = 0, exp_min = 0, exp_max = 0, exp_mc = 0;
   bit exp_av = 0, exp_mt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      win.delete();
      active = 0;
      last_seq = 0;
      exp_avg = 0; exp_min = 0; exp_max = 0; exp_mc = 0;
      exp_av = 0; exp_mt = 0;
   endtask

   task automatic model_step(input bit v, input int s, input int p, input bit c);
      int sum, mn, mx;
      exp_av = 0;
      exp_mt = 0;
      if (c) begin
         win.delete();
         active = 0;
         exp_mc = 0;
      end else if (v) begin
         if (!active) begin
            win = {p};
            active = 1;
            last_seq = s;
         end else if (s == (last_seq + 1) % (1 << SW)) begin
            win.push_back(p);
            last_seq = s;
            if (win.size() == WIN) begin
               sum = 0; mn = win[0]; mx = win[0];
               foreach (win[i]) begin
                  sum += win[i];
                  if (win[i] < mn) mn = win[i];
                  if (win[i] > mx) mx = win[i];
               end
               exp_avg = sum / WIN;
               exp_min = mn;
               exp_max = mx;
               exp_av  = 1;
               win.delete();
               active = 0;
            end
         end else begin
            exp_mt = 1;
            if (exp_mc != 65535) exp_mc++;
            win = {p};
            last_seq = s;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".avg_valid"}, 32'(avg_valid), 32'(exp_av));
      check({tag, ".missed_tag"}, 32'(missed_tag), 32'(exp_mt));
      check({tag, ".phase_avg"}, 32'(phase_avg), 32'(exp_avg));
      check({tag, ".phase_min"}, 32'(phase_min), 32'(exp_min));
      check({tag, ".phase_max"}, 32'(phase_max), 32'(exp_max));
      check({tag, ".missed_count"}, 32'(missed_count), 32'(exp_mc));
   endtask

   // One clock: drive at negedge, sample 1 time unit after the posedge.
   task automatic step(input string tag, input bit v, input int s, input int p, input bit c);
      @(negedge clk_sample);
      phase_tag_valid = v;
      phase_tag = {4'(s), 12'(p)};
      clear = c;
      model_step(v, s, p, c);
      @(posedge clk_sample);
      #1;
      phase_tag_valid = 1'b0;
      clear = 1'b0;
      if (avg_valid === 1'b1) av_pulses++;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      int seqs[$];
      int phs[$];
      int rseq;
      int first_av;

      // Reset state
      model_reset();
      #1;
      check_all("reset");
      #20;
      @(negedge clk_sample);
      rst = 1'b0;

      // 1: basic window, one tag per 5 cycles
      seqs = {0, 1, 2, 3}; phs = {10, 12, 14, 16};
      foreach (seqs[i]) begin
         step("t1", 1'b1, seqs[i], phs[i], 1'b0);
         idle("t1i", 4);
      end
      check("t1.avg13", 32'(phase_avg), 32'd13);

      // 2: sequence wrap 14,15,0,1
      seqs = {14, 15, 0, 1};
      foreach (seqs[i]) step("t2", 1'b1, seqs[i], 100, 1'b0);
      idle("t2i", 1);
      check("t2.mc0", 32'(missed_count), 32'd0);

      // 3: gap 0,1,3,4,5,6
      seqs = {0, 1, 3, 4, 5, 6}; phs = {1, 1, 8, 8, 8, 8};
      foreach (seqs[i]) step("t3", 1'b1, seqs[i], phs[i], 1'b0);
      idle("t3i", 1);
      check("t3.mc1", 32'(missed_count), 32'd1);
      check("t3.avg8", 32'(phase_avg), 32'd8);

      // 4: full-scale phases, then truncation
      for (int i = 0; i < 4; i++) step("t4a", 1'b1, 7 + i, 4095, 1'b0);
      check("t4.avg4095", 32'(phase_avg), 32'd4095);
      phs = {0, 0, 0, 3};
      foreach (phs[i]) step("t4b", 1'b1, 11 + i, phs[i], 1'b0);
      check("t4.max3", 32'(phase_max), 32'd3);

      // 5: back-to-back valid, then clear with a coincident tag
      av_pulses = 0;
      first_av = -1;
      for (int i = 0; i < 8; i++) begin
         step("t5a", 1'b1, i, 20 * i, 1'b0);
         if (avg_valid === 1'b1 && first_av < 0) first_av = i;
      end
      check("t5.pulses", 32'(av_pulses), 32'd2);
      check("t5.first", 32'(first_av), 32'd3);
      step("t5b", 1'b1, 8, 50, 1'b0);
      step("t5b", 1'b1, 9, 50, 1'b0);
      step("t5clr", 1'b1, 10, 50, 1'b1);
      check("t5.mc_clr", 32'(missed_count), 32'd0);
      for (int i = 0; i < 4; i++) step("t5c", 1'b1, i, 40 + i, 1'b0);
      check("t5.fresh", 32'(phase_avg), 32'd41);

      // 6: async reset between edges mid-window
      seqs = {0, 1, 2, 3}; phs = {10, 12, 14, 16};
      foreach (seqs[i]) step("t6a", 1'b1, seqs[i], phs[i], 1'b0);
      step("t6b", 1'b1, 3, 9, 1'b0);
      step("t6b", 1'b1, 4, 9, 1'b0);
      @(negedge clk_sample);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("t6rst");
      @(negedge clk_sample);
      rst = 1'b0;
      foreach (seqs[i]) step("t6c", 1'b1, seqs[i], phs[i], 1'b0);
      check("t6.avg13", 32'(phase_avg), 32'd13);

      // Randomized: mostly contiguous tags, occasional gaps, duplicates and clears
      rseq = 0;
      for (int i = 0; i < 400; i++) begin
         int r;
         bit v, c;
         r = int'($urandom_range(0, 99));
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 49) == 0);
         if (r < 6) rseq = int'($urandom_range(0, 15));
         else if (r < 9) rseq = rseq;
         else rseq = (rseq + 1) % 16;
         step("rnd", v, rseq, int'($urandom_range(0, 4095)), c);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
